// File: rtl/tdc_readout_arbiter.sv
// TDC readout scheduler: per-channel one-entry holding registers, a round-robin
// arbiter feeding a show-ahead FIFO, loss accounting and a level interrupt.
module tdc_readout_arbiter #(
  parameter int g_CHANNEL_COUNT   = 5,
  parameter int g_TS_WIDTH        = 32,
  parameter int g_FIFO_DEPTH_LOG2 = 4
) (
  input  logic                                  sys_clk,
  input  logic                                  rst_n_i,
  input  logic [g_CHANNEL_COUNT-1:0]            enable_i,
  input  logic [g_CHANNEL_COUNT-1:0]            det_i,
  input  logic [g_CHANNEL_COUNT-1:0]            pol_i,
  input  logic [g_CHANNEL_COUNT*g_TS_WIDTH-1:0] ts_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [2:0]                            out_chan_o,
  output logic                                  out_pol_o,
  output logic [g_TS_WIDTH-1:0]                 out_ts_o,
  output logic [g_FIFO_DEPTH_LOG2:0]            level_o,
  input  logic [g_FIFO_DEPTH_LOG2:0]            irq_thresh_i,
  output logic                                  irq_o,
  output logic [15:0]                           lost_o,
  output logic [g_CHANNEL_COUNT-1:0]            lost_ch_o,
  input  logic                                  clr_i
);
  localparam int N     = g_CHANNEL_COUNT;
  localparam int W     = g_TS_WIDTH;
  localparam int L     = g_FIFO_DEPTH_LOG2;
  localparam int LW    = L + 1;
  localparam int DEPTH = 1 << L;
  localparam int EW    = 3 + 1 + W;

  logic [1:0]    rst_sync;
  logic [N-1:0]  pend, hold_pol;
  logic [W-1:0]  hold_ts [N];
  logic [2:0]    rr;
  logic [EW-1:0] mem [DEPTH];
  logic [L-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          irq;
  logic [15:0]   lost;
  logic [N-1:0]  lost_ch;

  logic          live, pop, can_push, push, found, found_hi;
  logic [2:0]    gidx, gidx_hi, gidx_lo;
  logic [N-1:0]  det_en, req, gnt, loss;
  logic [3:0]    loss_cnt;
  logic [16:0]   lost_sum;
  logic          sel_pol;
  logic [W-1:0]  sel_ts;
  logic [EW-1:0] head;

  assign live        = rst_sync[1];
  assign det_en      = det_i & enable_i & {N{live}};
  assign req         = pend & enable_i;
  assign out_valid_o = (level != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign can_push    = (level != LW'(DEPTH)) | pop;
  assign push        = found & can_push;

  // Round robin: prefer the lowest pending channel above rr, else wrap to the lowest overall.
  always_comb begin
    found    = 1'b0;
    found_hi = 1'b0;
    gidx_hi  = '0;
    gidx_lo  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        found   = 1'b1;
        gidx_lo = 3'(k);
        if (3'(k) > rr) begin
          found_hi = 1'b1;
          gidx_hi  = 3'(k);
        end
      end
    end
    gidx = found_hi ? gidx_hi : gidx_lo;
  end

  always_comb begin
    gnt      = '0;
    sel_pol  = 1'b0;
    sel_ts   = '0;
    loss_cnt = '0;
    for (int k = 0; k < N; k++) begin
      if (gidx == 3'(k)) begin
        gnt[k]  = push;
        sel_pol = hold_pol[k];
        sel_ts  = hold_ts[k];
      end
    end
    loss = det_en & pend & ~gnt;
    for (int k = 0; k < N; k++) loss_cnt = loss_cnt + {3'b000, loss[k]};
  end

  assign lost_sum = {1'b0, lost} + {13'd0, loss_cnt};

  assign head       = mem[rd_ptr];
  assign out_chan_o = out_valid_o ? head[EW-1 -: 3] : '0;
  assign out_pol_o  = out_valid_o & head[W];
  assign out_ts_o   = out_valid_o ? head[W-1:0] : '0;
  assign level_o    = level;
  assign irq_o      = irq;
  assign lost_o     = lost;
  assign lost_ch_o  = lost_ch;

  always_ff @(posedge sys_clk or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  always_ff @(posedge sys_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend     <= '0;
      hold_pol <= '0;
      for (int k = 0; k < N; k++) hold_ts[k] <= '0;
      rr       <= 3'(N - 1);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      irq      <= 1'b0;
      lost     <= '0;
      lost_ch  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!enable_i[k]) begin
          pend[k] <= 1'b0;
        end else if (det_en[k] && (!pend[k] || gnt[k])) begin
          pend[k]     <= 1'b1;
          hold_pol[k] <= pol_i[k];
          hold_ts[k]  <= ts_i[k*W +: W];
        end else if (gnt[k]) begin
          pend[k] <= 1'b0;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + L'(1);
        rr     <= gidx;
      end
      if (pop) rd_ptr <= rd_ptr + L'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
      irq <= (level >= irq_thresh_i) && (level != '0);
      if (clr_i) begin
        lost    <= '0;
        lost_ch <= '0;
      end else begin
        lost    <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
        lost_ch <= lost_ch | loss;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= {gidx, sel_pol, sel_ts};
  end
endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Directed bench for tdc_readout_arbiter; expected output events are queued as
// stimulus is driven and compared in order as the FIFO head is popped.
module tb_tdc_readout_arbiter;
  localparam int N = 5;
  localparam int W = 32;
  localparam int L = 4;

  logic           sys_clk = 1'b0;
  logic           rst_n_i = 1'b0;
  logic [N-1:0]   enable_i = '1;
  logic [N-1:0]   det_i = '0;
  logic [N-1:0]   pol_i = '0;
  logic [N*W-1:0] ts_i = '0;
  logic           out_valid_o;
  logic           out_ready_i = 1'b0;
  logic [2:0]     out_chan_o;
  logic           out_pol_o;
  logic [W-1:0]   out_ts_o;
  logic [L:0]     level_o;
  logic [L:0]     irq_thresh_i = '0;
  logic           irq_o;
  logic [15:0]    lost_o;
  logic [N-1:0]   lost_ch_o;
  logic           clr_i = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]   chan;
    logic         pol;
    logic [W-1:0] ts;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_exp, mon_got;

  tdc_readout_arbiter #(
    .g_CHANNEL_COUNT(N), .g_TS_WIDTH(W), .g_FIFO_DEPTH_LOG2(L)
  ) dut (
    .sys_clk(sys_clk), .rst_n_i(rst_n_i), .enable_i(enable_i), .det_i(det_i),
    .pol_i(pol_i), .ts_i(ts_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_chan_o(out_chan_o), .out_pol_o(out_pol_o), .out_ts_o(out_ts_o),
    .level_o(level_o), .irq_thresh_i(irq_thresh_i), .irq_o(irq_o),
    .lost_o(lost_o), .lost_ch_o(lost_ch_o), .clr_i(clr_i)
  );

  always #5 sys_clk = ~sys_clk;

  // Every accepted head entry must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    if (rst_n_i && out_valid_o && out_ready_i) begin
      mon_got = {out_chan_o, out_pol_o, out_ts_o};
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL pop_unexpected: observed %0h expected no entry", mon_got);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        checks++;
        assert (mon_got === mon_exp) else begin
          errors++;
          $error("FAIL pop_order: observed %0h expected %0h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ev(input int ch, input logic p, input logic [W-1:0] t, input bit keep);
    det_i[ch]        = 1'b1;
    pol_i[ch]        = p;
    ts_i[ch*W +: W]  = t;
    if (keep) exp_q.push_back(ev_t'({3'(ch), p, t}));
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    out_ready_i = 1'b1;
    while ((exp_q.size() != 0 || level_o != '0) && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size() == 0 && level_o == '0), 32'd1);
    out_ready_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_level"}, 32'(level_o), 32'd0);
    chk({tag, "_irq"}, 32'(irq_o), 32'd0);
    chk({tag, "_lost"}, 32'(lost_o), 32'd0);
    chk({tag, "_lost_ch"}, 32'(lost_ch_o), 32'd0);
    chk({tag, "_chan"}, 32'(out_chan_o), 32'd0);
    chk({tag, "_pol"}, 32'(out_pol_o), 32'd0);
    chk({tag, "_ts"}, out_ts_o, 32'd0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(negedge sys_clk);
    rst_n_i = 1'b1;
    tick();
    tick();

    // Simultaneous burst on ch0/1/4 from reset pointer: 0,1,4 twice.
    out_ready_i = 1'b1;
    for (int r = 0; r < 2; r++) begin
      ev(0, 1'b0, 32'h100 + 32'(r), 1);
      ev(1, 1'b1, 32'h110 + 32'(r), 1);
      ev(4, 1'b0, 32'h140 + 32'(r), 1);
      tick();
      det_i = '0;
      tick(); chk("burst_first", 32'(out_chan_o), 32'd0);
      tick(); chk("burst_second", 32'(out_chan_o), 32'd1);
      tick(); chk("burst_third", 32'(out_chan_o), 32'd4);
      tick(); chk("burst_done", 32'(out_valid_o), 32'd0);
    end

    // Single event latency.
    out_ready_i = 1'b0;
    ev(2, 1'b1, 32'h00001234, 1);
    tick();
    det_i = '0;
    chk("single_not_yet", 32'(out_valid_o), 32'd0);
    tick();
    chk("single_valid", 32'(out_valid_o), 32'd1);
    chk("single_chan", 32'(out_chan_o), 32'd2);
    chk("single_pol", 32'(out_pol_o), 32'd1);
    chk("single_ts", out_ts_o, 32'h1234);
    chk("single_level", 32'(level_o), 32'd1);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("single_level_after_pop", 32'(level_o), 32'd0);

    // Grant and load on the same channel in the same cycle.
    out_ready_i = 1'b1;
    ev(3, 1'b0, 32'h55, 1);
    tick();
    ev(3, 1'b1, 32'hAA, 1);
    tick();
    det_i = '0;
    chk("grant_load_head", out_ts_o, 32'h55);
    drain(10);
    chk("grant_load_lost", 32'(lost_o), 32'd0);

    // Disable a pending channel: flushed, no write, later detections ignored.
    out_ready_i = 1'b1;
    ev(1, 1'b0, 32'h77, 0);
    tick();
    det_i = '0;
    enable_i[1] = 1'b0;
    tick();
    tick();
    chk("disable_no_write", 32'(level_o), 32'd0);
    ev(1, 1'b0, 32'h78, 0);
    tick();
    det_i = '0;
    tick();
    chk("disable_lost", 32'(lost_o), 32'd0);
    chk("disable_lost_ch", 32'(lost_ch_o), 32'd0);
    enable_i[1] = 1'b1;
    tick();
    tick();
    chk("disable_flushed", 32'(out_valid_o), 32'd0);

    // Level interrupt at threshold 3.
    out_ready_i = 1'b0;
    irq_thresh_i = 5'd3;
    ev(0, 1'b1, 32'h300, 1);
    ev(1, 1'b0, 32'h301, 1);
    ev(2, 1'b1, 32'h302, 1);
    tick();
    det_i = '0;
    tick(); chk("irq_level1", 32'(level_o), 32'd1);
    tick(); chk("irq_level2", 32'(level_o), 32'd2);
    tick(); chk("irq_level3", 32'(level_o), 32'd3);
    chk("irq_not_yet", 32'(irq_o), 32'd0);
    tick(); chk("irq_rise", 32'(irq_o), 32'd1);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("irq_level_drop", 32'(level_o), 32'd2);
    tick(); chk("irq_fall", 32'(irq_o), 32'd0);
    drain(10);

    // Overflow: 21 events with no consumer fill the FIFO and all 5 holding registers.
    out_ready_i = 1'b0;
    for (int i = 0; i < 21; i++) begin
      det_i = '0;
      ev(i % 5, 1'(i % 2), 32'h1000 + 32'(i), 1);
      tick();
    end
    det_i = '0;
    tick();
    tick();
    chk("ovf_level", 32'(level_o), 32'd16);
    chk("ovf_head", out_ts_o, 32'h1000);
    chk("ovf_no_loss_yet", 32'(lost_o), 32'd0);
    for (int k = 0; k < N; k++) ev(k, 1'b1, 32'hDEAD, 0);
    tick();
    det_i = '0;
    chk("ovf_lost5", 32'(lost_o), 32'd5);
    chk("ovf_lost_ch", 32'(lost_ch_o), 32'h1F);
    ev(0, 1'b0, 32'hBEEF, 0);
    tick();
    det_i = '0;
    chk("ovf_lost6", 32'(lost_o), 32'd6);
    ev(2, 1'b0, 32'hBEEF, 0);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    det_i = '0;
    chk("clr_lost", 32'(lost_o), 32'd0);
    chk("clr_lost_ch", 32'(lost_ch_o), 32'd0);
    chk("ovf_head_stable", out_ts_o, 32'h1000);
    drain(60);

    // Reset in the middle of activity.
    for (int i = 0; i < 7; i++) begin
      det_i = '0;
      ev(i % 5, 1'b1, 32'h2000 + 32'(i), 0);
      tick();
    end
    det_i = '0;
    tick();
    tick();
    chk("mid_level7", 32'(level_o), 32'd7);
    chk("mid_irq", 32'(irq_o), 32'd1);
    for (int k = 0; k < N; k++) ev(k, 1'b0, 32'h3000, 0);
    tick();
    det_i = '0;
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_zero("async_reset");
    exp_q.delete();
    @(negedge sys_clk);
    rst_n_i = 1'b1;
    tick();
    ev(1, 1'b0, 32'h5555, 0);
    tick();
    det_i = '0;
    ev(4, 1'b1, 32'h4444, 1);
    tick();
    det_i = '0;
    chk("post_reset_early", 32'(out_valid_o), 32'd0);
    tick();
    chk("post_reset_valid", 32'(out_valid_o), 32'd1);
    chk("post_reset_chan", 32'(out_chan_o), 32'd4);
    chk("post_reset_ts", out_ts_o, 32'h4444);
    chk("post_reset_level", 32'(level_o), 32'd1);
    drain(10);
    chk("post_reset_lost", 32'(lost_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
